program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 119 +++++++++++
 tb/tb_program_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Streams an image into the processor RAM, holding the CPU in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic [WORD_W-1:0]        rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     cpu_n_reset,
  output logic                     RAM_NCE,
  output logic                     RAM_NWE,
  output logic                     RAM_NOE,
  output logic [WORD_W-OP_W-1:0]   addrbus,
  inout  wire  [WORD_W-1:0]        sysbus,
  output logic                     busy
);

  localparam int AW = WORD_W - OP_W;
  localparam logic [AW-1:0] C_ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_RUN    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                rx_ready_q, cpu_n_reset_q, nce_q, nwe_q, drive_q, busy_q;
  logic                write_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        // Last address exits instead of incrementing, so addr never wraps.
        if (addr_q == C_ADDR_LAST) begin
          state_d = S_RUN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RUN: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign write_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

  // Outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      rx_ready_q    <= 1'b0;
      cpu_n_reset_q <= 1'b0;
      nce_q         <= 1'b1;
      nwe_q         <= 1'b1;
      drive_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      rx_ready_q    <= (state_d == S_FETCH);
      cpu_n_reset_q <= (state_d == S_RUN);
      nce_q         <= !write_d;
      nwe_q         <= (state_d != S_STROBE);
      drive_q       <= write_d;
      busy_q        <= (state_d != S_IDLE) && (state_d != S_RUN);
    end
  end

  assign rx_ready    = rx_ready_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign RAM_NCE     = nce_q;
  assign RAM_NWE     = nwe_q;
  assign RAM_NOE     = 1'b1;
  assign addrbus     = addr_q;
  assign busy        = busy_q;
  assign sysbus      = drive_q ? data_q : {WORD_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomised bench for program_loader against a mode/phase model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_program_loader;
  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int AW     = WORD_W - OP_W;
  localparam int N      = 1 << AW;

  logic              clock    = 1'b0;
  logic              n_reset  = 1'b0;
  logic              start    = 1'b0;
  logic              rx_valid = 1'b0;
  logic [WORD_W-1:0] rx_data  = '0;
  logic [WORD_W-1:0] cpu_val  = 8'h3C;
  wire               rx_ready, cpu_n_reset, RAM_NCE, RAM_NWE, RAM_NOE, busy;
  wire  [AW-1:0]     addrbus;
  wire  [WORD_W-1:0] sysbus;

  // The processor side drives the shared bus whenever it is released.
  assign sysbus = cpu_n_reset ? cpu_val : {WORD_W{1'bz}};

  program_loader #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock(clock), .n_reset(n_reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .cpu_n_reset(cpu_n_reset),
    .RAM_NCE(RAM_NCE), .RAM_NWE(RAM_NWE), .RAM_NOE(RAM_NOE),
    .addrbus(addrbus), .sysbus(sysbus), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int wr_next  = 0;
  logic [WORD_W-1:0] img [N];
  logic [WORD_W-1:0] ram [N];

  task automatic checkv(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is a word index plus a phase (0 waiting for a word, 1..3 write cycle).
  typedef enum int {M_IDLE, M_LOAD, M_RUN} mmode_t;
  mmode_t            m_mode = M_IDLE;
  int                m_ph   = 0;
  int                m_idx  = 0;
  logic [WORD_W-1:0] m_data = '0;
  logic [WORD_W-1:0] m_mem [N];

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_mode <= M_IDLE;
      m_ph   <= 0;
      m_idx  <= 0;
      m_data <= '0;
    end else begin
      case (m_mode)
        M_IDLE, M_RUN: if (start) begin m_mode <= M_LOAD; m_ph <= 0; m_idx <= 0; end
        default: begin
          if (m_ph == 0) begin
            if (rx_valid) begin m_data <= rx_data; m_ph <= 1; end
          end else if (m_ph < 3) begin
            if (m_ph == 2) m_mem[m_idx] <= m_data;
            m_ph <= m_ph + 1;
          end else if (m_idx == N - 1) begin
            m_mode <= M_RUN;
          end else begin
            m_idx <= m_idx + 1;
            m_ph  <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      bit ld, wr;
      ld = (m_mode == M_LOAD);
      wr = ld && (m_ph != 0);
      checkv("rx_ready",    int'(rx_ready),    int'(ld && m_ph == 0));
      checkv("cpu_n_reset", int'(cpu_n_reset), int'(m_mode == M_RUN));
      checkv("busy",        int'(busy),        int'(ld));
      checkv("RAM_NCE",     int'(RAM_NCE),     int'(!wr));
      checkv("RAM_NWE",     int'(RAM_NWE),     int'(!(wr && m_ph == 2)));
      checkv("RAM_NOE",     int'(RAM_NOE),     1);
      checkv("nwe_without_nce", int'(!RAM_NWE && RAM_NCE), 0);
      if (wr) begin
        checkv("addrbus", int'(addrbus), m_idx);
        checkv("sysbus",  int'(sysbus),  int'(m_data));
      end
      if (m_mode == M_RUN) begin
        checkv("sysbus_cpu_side", int'(sysbus), int'(cpu_val));
        cpu_val <= WORD_W'($urandom);
      end
      if (!RAM_NCE && !RAM_NWE) begin
        ram[addrbus] = sysbus;
        checkv("write_order", int'(addrbus), wr_next);
        wr_next++;
      end
    end
  end

  task automatic run_load(input bit rand_valid, input int start_word,
                          input int reset_word, input bit timed);
    int idx = 0;
    int cyc = 0;
    int acc_edge = -1;
    bit acc;
    bit was_run;
    wr_next = 0;
    was_run = cpu_n_reset;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    if (was_run) checkv("cpu_held_next_cycle", int'(cpu_n_reset), 0);
    rx_data  = img[0];
    rx_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 2000) begin
      acc = rx_ready && rx_valid;
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      if (acc) begin
        if (acc_edge < 0) acc_edge = cyc;
        idx++;
      end
      if (cpu_n_reset) break;
      if (!RAM_NWE && int'(addrbus) == start_word) start = 1'b1;
      if (!RAM_NWE && int'(addrbus) == reset_word) begin
        n_reset = 1'b0;
        #1;
        checkv("rst_NWE", int'(RAM_NWE), 1);
        checkv("rst_NCE", int'(RAM_NCE), 1);
        checkv("rst_cpu", int'(cpu_n_reset), 0);
        checkv("rst_busy", int'(busy), 0);
        checkv("rst_rx_ready", int'(rx_ready), 0);
        rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 n_reset = 1'b1;
        return;
      end
      rx_data  = img[(idx < N) ? idx : N - 1];
      rx_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rx_valid = 1'b0;
    checkv("run_reached", int'(cpu_n_reset), 1);
    checkv("words_written", wr_next, N);
    if (timed) checkv("load_cycles", cyc - acc_edge + 1, 4 * N);
    for (int i = 0; i < N; i++) begin
      checkv("ram_image", int'(ram[i]), int'(img[i]));
      checkv("model_image", int'(m_mem[i]), int'(img[i]));
    end
  endtask

  initial begin
    @(posedge clock); #1 chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkv("reset_rx_ready", int'(rx_ready), 0);
    checkv("reset_cpu", int'(cpu_n_reset), 0);
    checkv("reset_NCE", int'(RAM_NCE), 1);
    checkv("reset_NWE", int'(RAM_NWE), 1);
    checkv("reset_busy", int'(busy), 0);
    n_reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkv("idle_holds_cpu", int'(cpu_n_reset), 0);
    checkv("idle_not_busy", int'(busy), 0);

    // Full-rate load of an ascending image
    for (int i = 0; i < N; i++) img[i] = WORD_W'(i);
    run_load(1'b0, -1, -1, 1'b1);
    checkv("ram5_literal", int'(ram[5]), 5);
    checkv("ram31_literal", int'(ram[31]), 31);

    // Reload from RUN with a descending image
    for (int i = 0; i < N; i++) img[i] = WORD_W'(8'hFF - i);
    run_load(1'b0, -1, -1, 1'b0);
    checkv("ram0_literal", int'(ram[0]), 8'hFF);
    checkv("ram31_desc_literal", int'(ram[31]), 8'hE0);

    // Throttled source with a start pulse inside word 5's strobe
    for (int i = 0; i < N; i++) img[i] = WORD_W'($urandom);
    run_load(1'b1, 5, -1, 1'b0);

    // Reset during word 10's strobe, then a complete reload
    for (int i = 0; i < N; i++) img[i] = WORD_W'($urandom);
    run_load(1'b1, -1, 10, 1'b0);
    for (int i = 0; i < N; i++) img[i] = WORD_W'($urandom);
    run_load(1'b1, -1, -1, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
